// File: rtl/conv_window_buffer.sv
// rtl/conv_window_buffer.sv - sliding window of DEPTH slices fed through a one-slice staging register
// Slice 0 is the newest; a commit shifts every slice up by one and drops the oldest.
module conv_window_buffer #(
  parameter int DW     = 8,
  parameter int SLICE  = 3,
  parameter int DEPTH  = 3,
  parameter int STRIDE = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          wen,
  input  logic                          pop,
  input  logic [DW*SLICE-1:0]           wdata,
  output logic [DW*SLICE*DEPTH-1:0]     rdata,
  output logic                          win_valid,
  output logic [$clog2(DEPTH+1)-1:0]    fill,
  output logic                          staged,
  output logic                          drop
);

  localparam int SLW = DW * SLICE;
  localparam int WW  = SLW * DEPTH;
  localparam int FW  = $clog2(DEPTH + 1);
  localparam int SCW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  logic [SLW-1:0] stage_q;
  logic [SCW-1:0] stride_q;
  logic           commit;
  logic           full_next;
  logic [FW-1:0]  fill_next;
  logic [WW-1:0]  win_next;

  always_comb begin
    commit    = pop & staged;
    fill_next = (fill == FW'(DEPTH)) ? fill : fill + FW'(1);
    full_next = (fill_next == FW'(DEPTH));
    // Shifting by a whole slice discards the oldest slice; with DEPTH=1 it empties the window.
    win_next  = (rdata << SLW) | WW'(stage_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata     <= '0;
      win_valid <= 1'b0;
      fill      <= '0;
      staged    <= 1'b0;
      drop      <= 1'b0;
      stage_q   <= '0;
      stride_q  <= '0;
    end else if (clear) begin
      rdata     <= '0;
      win_valid <= 1'b0;
      fill      <= '0;
      staged    <= 1'b0;
      drop      <= 1'b0;
      stage_q   <= '0;
      stride_q  <= '0;
    end else begin
      win_valid <= 1'b0;
      if (commit) begin
        rdata <= win_next;
        fill  <= fill_next;
        // Stride only counts commits that leave the window full.
        if (full_next) begin
          win_valid <= (stride_q == '0);
          stride_q  <= (stride_q == SCW'(STRIDE - 1)) ? '0 : stride_q + SCW'(1);
        end
      end
      if (wen) begin
        stage_q <= wdata;
        staged  <= 1'b1;
        if (staged && !pop) drop <= 1'b1;
      end else if (commit) begin
        staged <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_buffer.sv
// tb/tb_conv_window_buffer.sv - self-checking bench for conv_window_buffer (STRIDE=1 and STRIDE=2)
module tb_conv_window_buffer;

  logic        clk = 1'b0;
  logic        rst, clear, wen, pop;
  logic [23:0] wdata;
  logic [71:0] rdata1, rdata2;
  logic        wv1, wv2, st1, st2, dr1, dr2;
  logic [1:0]  fill1, fill2;

  always #5 clk = ~clk;

  conv_window_buffer #(.DW(8), .SLICE(3), .DEPTH(3), .STRIDE(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .wen(wen), .pop(pop), .wdata(wdata),
    .rdata(rdata1), .win_valid(wv1), .fill(fill1), .staged(st1), .drop(dr1)
  );

  conv_window_buffer #(.DW(8), .SLICE(3), .DEPTH(3), .STRIDE(2)) dut2 (
    .clk(clk), .rst(rst), .clear(clear), .wen(wen), .pop(pop), .wdata(wdata),
    .rdata(rdata2), .win_valid(wv2), .fill(fill2), .staged(st2), .drop(dr2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: list of committed slices (newest first) and a commit count.
  logic [23:0] hist[$];
  int          n_commits;
  logic [23:0] m_stage;
  logic        m_staged, m_drop, m_p1, m_p2;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] sl(input int a, input int b, input int c);
    return {c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic logic [71:0] exp_win();
    logic [71:0] w = '0;
    for (int d = 0; d < hist.size(); d++) w[24*d +: 24] = hist[d];
    return w;
  endfunction

  function automatic logic [1:0] exp_fill();
    return (n_commits >= 3) ? 2'd3 : 2'(n_commits);
  endfunction

  task automatic model_reset();
    hist.delete();
    n_commits = 0;
    m_stage   = '0;
    m_staged  = 1'b0;
    m_drop    = 1'b0;
    m_p1      = 1'b0;
    m_p2      = 1'b0;
  endtask

  task automatic model_edge(input logic c, input logic w, input logic p, input logic [23:0] d);
    logic com;
    if (!rst || c) begin
      model_reset();
      return;
    end
    m_p1 = 1'b0;
    m_p2 = 1'b0;
    com  = p && m_staged;
    if (com) begin
      hist.push_front(m_stage);
      if (hist.size() > 3) void'(hist.pop_back());
      n_commits++;
      if (n_commits >= 3) begin
        m_p1 = 1'b1;
        m_p2 = ((n_commits - 3) % 2) == 0;
      end
    end
    if (w) begin
      if (m_staged && !p) m_drop = 1'b1;
      m_stage  = d;
      m_staged = 1'b1;
    end else if (com) begin
      m_staged = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".rdata1"}, rdata1, exp_win());
    check({tag, ".rdata2"}, rdata2, exp_win());
    check({tag, ".fill1"}, fill1, exp_fill());
    check({tag, ".fill2"}, fill2, exp_fill());
    check({tag, ".wv1"}, wv1, m_p1);
    check({tag, ".wv2"}, wv2, m_p2);
    check({tag, ".staged1"}, st1, m_staged);
    check({tag, ".staged2"}, st2, m_staged);
    check({tag, ".drop1"}, dr1, m_drop);
    check({tag, ".drop2"}, dr2, m_drop);
  endtask

  task automatic step(input string tag, input logic c, input logic w, input logic p, input logic [23:0] d);
    clear = c;
    wen   = w;
    pop   = p;
    wdata = d;
    @(posedge clk);
    model_edge(c, w, p, d);
    #1;
    compare_all(tag);
    clear = 1'b0;
    wen   = 1'b0;
    pop   = 1'b0;
  endtask

  logic [5:0]  mask1, mask2;
  logic [71:0] r_save;
  logic [1:0]  f_save;

  initial begin
    rst = 1'b0; clear = 1'b0; wen = 1'b0; pop = 1'b0; wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst = 1'b1;

    // Fill the window with three slices
    step("s1w", 0, 1, 0, sl(1, 2, 3));
    step("s1p", 0, 0, 1, '0);
    check("fill_after_1", fill1, 2'd1);
    step("s2w", 0, 1, 0, sl(4, 5, 6));
    step("s2p", 0, 0, 1, '0);
    check("fill_after_2", fill1, 2'd2);
    step("s3w", 0, 1, 0, sl(7, 8, 9));
    step("s3p", 0, 0, 1, '0);
    check("fill_after_3", fill1, 2'd3);
    check("wv_after_3", wv1, 1'b1);
    check("slice0_789", rdata1[23:0], sl(7, 8, 9));
    check("slice2_123", rdata1[71:48], sl(1, 2, 3));

    // Fourth slice keeps pulsing at stride 1
    step("s4w", 0, 1, 0, sl(10, 11, 12));
    step("s4p", 0, 0, 1, '0);
    check("wv_after_4", wv1, 1'b1);
    check("slice2_456", rdata1[71:48], sl(4, 5, 6));
    check("fill_sat", fill1, 2'd3);

    // Six commits from empty: stride 2 pulses on commits 3 and 5
    step("clr32", 1, 0, 0, '0);
    mask1 = '0;
    mask2 = '0;
    for (int k = 0; k < 6; k++) begin
      step("str_w", 0, 1, 0, sl(k, k + 20, k + 40));
      step("str_p", 0, 0, 1, '0);
      mask1[k] = wv1;
      mask2[k] = wv2;
    end
    check("stride1_mask", mask1, 6'b111100);
    check("stride2_mask", mask2, 6'b010100);

    // Overwrite before commit sets drop; the later value is committed
    step("dropA", 0, 1, 0, 24'hAAAAAA);
    step("dropB", 0, 1, 0, 24'hBBBBBB);
    check("drop_set", dr1, 1'b1);
    step("dropP", 0, 0, 1, '0);
    check("commit_B", rdata1[23:0], 24'hBBBBBB);
    r_save = rdata1;
    f_save = fill1;
    step("idle_pop", 0, 0, 1, '0);
    check("idle_pop_rdata", rdata1, r_save);
    check("idle_pop_fill", fill1, f_save);

    // Simultaneous wen+pop with and without staged data
    step("wpC", 0, 1, 0, 24'hC0C1C2);
    step("wpD", 0, 1, 1, 24'hD0D1D2);
    check("wp_old_commit", rdata1[23:0], 24'hC0C1C2);
    check("wp_staged", st1, 1'b1);
    step("wpDp", 0, 0, 1, '0);
    r_save = rdata1;
    f_save = fill1;
    step("wpE", 0, 1, 1, 24'hE0E1E2);
    check("wp_nobypass_rdata", rdata1, r_save);
    check("wp_nobypass_fill", fill1, f_save);
    check("wp_nobypass_staged", st1, 1'b1);

    // Clear beats wen/pop
    step("clr_wp", 1, 1, 1, 24'hF0F1F2);
    check("clear_rdata", rdata1, 72'd0);
    check("clear_staged", st1, 1'b0);
    check("clear_drop", dr1, 1'b0);

    // Asynchronous reset in the middle of a clock high phase at fill=2
    step("ar1w", 0, 1, 0, 24'h111111);
    step("ar1p", 0, 0, 1, '0);
    step("ar2w", 0, 1, 0, 24'h222222);
    step("ar2p", 0, 1, 1, 24'h333333);
    check("ar_fill2", fill1, 2'd2);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    step("ar_held", 0, 1, 1, 24'h444444);
    rst = 1'b1;
    step("ar_rw", 0, 1, 0, 24'h555555);
    step("ar_rp", 0, 0, 1, '0);
    check("ar_resume_fill", fill1, 2'd1);
    check("ar_resume_slice0", rdata1[23:0], 24'h555555);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, 24'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
